// File: rtl/fifo_drain_ctrl_if.sv
// FIFO read-side and downstream stream signals of fifo_drain_ctrl.
// master: the drain controller. slave: the FIFO/consumer side.
interface fifo_drain_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rden;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (
    input  fifo_empty, fifo_rdata, i_ready,
    output fifo_rden, o_valid, o_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, i_ready,
    input  fifo_rden, o_valid, o_data
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for the 8-deep single-clock FIFO: unloads a programmed
// burst of words, absorbs the FIFO's 1-cycle read latency with a 2-entry skid
// buffer and presents the words on a valid/ready stream.
// Optional feature: define FIFO_DRAIN_STALL_CNT_EN to build the back-pressure
// stall counter; otherwise stall_cnt is tied to 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing FIFO reads until len_q words have been requested
// FLUSH | all reads issued; waiting for in-flight word and buffer to drain
// DONE  | one-cycle done pulse, then back to IDLE
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] i_len,
  fifo_drain_ctrl_if.master    dif,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [1:0]            buf_cnt_q;

  logic       start_acc;
  logic       valid;
  logic       pop;
  logic [1:0] occ;
  logic       rden;
  logic       last_read;
  logic       drained;

  // Handshake, credit and read-issue decode.
  // The credit counts the pop happening this cycle so a word leaving the
  // buffer frees its slot immediately; this keeps one read per cycle under
  // full throughput while still bounding buffer + in-flight at 2.
  always_comb begin
    start_acc = (state_q == S_IDLE) && start;
    valid     = (buf_cnt_q != 2'd0);
    pop       = valid && dif.i_ready;
    occ       = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    rden      = (state_q == S_RUN) && !dif.fifo_empty &&
                (issued_q < len_q) && (occ < 2'd2);
    last_read = rden && (issued_q == len_q - 1'b1);
    drained   = !inflight_q &&
                ((buf_cnt_q == 2'd0) || ((buf_cnt_q == 2'd1) && pop));
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (i_len != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_read) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (drained) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Burst length, issued-read counter and in-flight flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rden;
      if (start_acc) begin
        len_q    <= i_len;
        issued_q <= '0;
      end else if (rden) begin
        issued_q <= issued_q + 1'b1;
      end
    end
  end

  // Skid buffer: entry 0 is the head; the FIFO word lands the cycle after rden.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      buf_cnt_q <= 2'd0;
    end else begin
      case ({inflight_q, pop})
        2'b10: begin
          buf_q[buf_cnt_q[0]] <= dif.fifo_rdata;
          buf_cnt_q           <= buf_cnt_q + 2'd1;
        end
        2'b01: begin
          buf_q[0]  <= buf_q[1];
          buf_cnt_q <= buf_cnt_q - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_q == 2'd1) begin
            buf_q[0] <= dif.fifo_rdata;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= dif.fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign dif.fifo_rden = rden;
  assign dif.o_valid   = valid;
  assign dif.o_data    = buf_q[0];

`ifdef FIFO_DRAIN_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  // Saturating count of cycles where the consumer holds off a valid word.
  always_ff @(posedge clk) begin
    if (!rst_n)                                       stall_q <= '0;
    else if (start_acc)                               stall_q <= '0;
    else if (valid && !dif.i_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
